// File: rtl/keypad_entry_if.sv
// Keypad scanner bus: row drive / column sense plus the entry results.
interface keypad_entry_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] value;
  logic [2:0]  digits;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic        entry_stb;

  // Scanner side: drives rows and results, senses columns.
  modport master (
    output row,
    input  col,
    output value,
    output digits,
    output key_valid,
    output key_code,
    output entry,
    output entry_stb
  );

  // Keypad / consumer side: returns columns, observes everything else.
  modport slave (
    input  row,
    output col,
    input  value,
    input  digits,
    input  key_valid,
    input  key_code,
    input  entry,
    input  entry_stb
  );
endinterface

// File: rtl/keypad_entry.sv
// Scanned 4x4 keypad reader: row scan, frame debounce, key decode and a
// 4-digit decimal entry register with clear, backspace and commit.
module keypad_entry #(
  parameter int unsigned SCAN_DIV = 66_666,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic           clk,
  input  logic           rst,
  keypad_entry_if.master bus
);

  localparam int unsigned CNT_W = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam int unsigned DB_W  = 4;
  localparam int unsigned VAL_W = 16;
  localparam int unsigned WIDE_W = VAL_W + 1;

  localparam logic [CNT_W-1:0] SCAN_TC = CNT_W'(SCAN_DIV);
  localparam logic [DB_W-1:0]  DB_TC   = DB_W'(DEBOUNCE);

  // Debounce states
  localparam logic [0:0] ARMED = 1'b0;
  localparam logic [0:0] HELD  = 1'b1;

  // Frame result, encoded as a saturating count of low column bits
  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Physical position to key code
  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0:    k = 4'd1;
      4'h1:    k = 4'd2;
      4'h2:    k = 4'd3;
      4'h3:    k = 4'd10;
      4'h4:    k = 4'd4;
      4'h5:    k = 4'd5;
      4'h6:    k = 4'd6;
      4'h7:    k = 4'd11;
      4'h8:    k = 4'd7;
      4'h9:    k = 4'd8;
      4'hA:    k = 4'd9;
      4'hB:    k = 4'd12;
      4'hC:    k = 4'd14;
      4'hD:    k = 4'd0;
      4'hE:    k = 4'd15;
      default: k = 4'd13;
    endcase
    return k;
  endfunction

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       row_idx;
  logic [3:0]       row_q;
  logic             tick_c;
  logic             frame_end_c;

  logic [1:0]       lows_acc;
  logic [3:0]       code_acc;

  logic [3:0]       low_c;
  logic [2:0]       row_low_cnt_c;
  logic [1:0]       row_sat_c;
  logic [1:0]       col_idx_c;
  logic [3:0]       row_code_c;
  logic [2:0]       sum_c;
  logic [1:0]       frame_lows_c;
  logic [3:0]       frame_code_c;

  logic [0:0]       state, state_n;
  logic [3:0]       cand, cand_n;
  logic [DB_W-1:0]  cnt, cnt_n;
  logic [DB_W-1:0]  rcnt, rcnt_n;
  logic [DB_W-1:0]  cnt_inc_c;
  logic [DB_W-1:0]  rcnt_inc_c;
  logic             accept_c;

  logic [VAL_W-1:0]  value_q, value_n;
  logic [2:0]        digits_q, digits_n;
  logic              key_valid_q;
  logic [3:0]        key_code_q, key_code_n;
  logic [VAL_W-1:0]  entry_q, entry_n;
  logic              entry_stb_q, entry_stb_n;
  logic [WIDE_W-1:0] append_c;

  assign tick_c      = (scan_cnt == SCAN_TC);
  assign frame_end_c = tick_c && (row_idx == 2'd3);

  // Row dwell counter, row index and registered one-hot-low row drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      row_idx  <= 2'd0;
      row_q    <= 4'b1110;
    end else if (tick_c) begin
      scan_cnt <= '0;
      row_idx  <= row_idx + 2'd1;
      row_q    <= ~(4'b0001 << (row_idx + 2'd1));
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Decode the columns of the row currently being driven
  always_comb begin
    low_c         = ~bus.col;
    row_low_cnt_c = 3'(low_c[0]) + 3'(low_c[1]) + 3'(low_c[2]) + 3'(low_c[3]);
    row_sat_c     = (row_low_cnt_c >= 3'd2) ? RES_MULTI : row_low_cnt_c[1:0];
    if (low_c[0])      col_idx_c = 2'd0;
    else if (low_c[1]) col_idx_c = 2'd1;
    else if (low_c[2]) col_idx_c = 2'd2;
    else               col_idx_c = 2'd3;
    row_code_c = key_lookup(row_idx, col_idx_c);
  end

  // Fold the current row into the running frame result
  always_comb begin
    sum_c        = 3'(lows_acc) + 3'(row_sat_c);
    frame_lows_c = (sum_c >= 3'd2) ? RES_MULTI : sum_c[1:0];
    frame_code_c = (lows_acc != RES_NONE) ? code_acc : row_code_c;
  end

  // Frame accumulator, restarted after each frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lows_acc <= RES_NONE;
      code_acc <= 4'd0;
    end else if (tick_c) begin
      lows_acc <= frame_end_c ? RES_NONE : frame_lows_c;
      code_acc <= frame_end_c ? 4'd0 : frame_code_c;
    end
  end

  // Debounce state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARMED;
      cand  <= 4'd0;
      cnt   <= '0;
      rcnt  <= '0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
      rcnt  <= rcnt_n;
    end
  end

  // Debounce next state, evaluated once per frame end
  always_comb begin
    state_n    = state;
    cand_n     = cand;
    cnt_n      = cnt;
    rcnt_n     = rcnt;
    accept_c   = 1'b0;
    cnt_inc_c  = (frame_code_c == cand) ? cnt + 1'b1 : DB_W'(1);
    rcnt_inc_c = rcnt + 1'b1;
    if (frame_end_c) begin
      case (state)
        ARMED: begin
          if (frame_lows_c == RES_SINGLE) begin
            cand_n = frame_code_c;
            if (cnt_inc_c >= DB_TC) begin
              accept_c = 1'b1;
              state_n  = HELD;
              cnt_n    = '0;
              rcnt_n   = '0;
            end else begin
              cnt_n = cnt_inc_c;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: begin
          if (frame_lows_c == RES_NONE) begin
            if (rcnt_inc_c >= DB_TC) begin
              state_n = ARMED;
              cnt_n   = '0;
              rcnt_n  = '0;
            end else begin
              rcnt_n = rcnt_inc_c;
            end
          end else begin
            rcnt_n = '0;
          end
        end
      endcase
    end
  end

  // Entry datapath: apply the accepted key to value/digits/entry
  always_comb begin
    value_n     = value_q;
    digits_n    = digits_q;
    entry_n     = entry_q;
    entry_stb_n = 1'b0;
    key_code_n  = key_code_q;
    append_c    = WIDE_W'(value_q) * WIDE_W'(10) + WIDE_W'(cand_n);
    if (accept_c) begin
      key_code_n = cand_n;
      if (cand_n <= 4'd9) begin
        if (digits_q < 3'd4) begin
          value_n  = VAL_W'(append_c);
          digits_n = digits_q + 3'd1;
        end
      end else if (cand_n == KEY_A) begin
        value_n  = '0;
        digits_n = 3'd0;
      end else if (cand_n == KEY_B) begin
        if (digits_q != 3'd0) begin
          value_n  = value_q / VAL_W'(10);
          digits_n = digits_q - 3'd1;
        end
      end else if (cand_n == KEY_HASH) begin
        entry_n     = value_q;
        entry_stb_n = 1'b1;
        value_n     = '0;
        digits_n    = 3'd0;
      end
    end
  end

  // Registered entry outputs and key pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q     <= '0;
      digits_q    <= 3'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      entry_q     <= '0;
      entry_stb_q <= 1'b0;
    end else begin
      value_q     <= value_n;
      digits_q    <= digits_n;
      key_valid_q <= accept_c;
      key_code_q  <= key_code_n;
      entry_q     <= entry_n;
      entry_stb_q <= entry_stb_n;
    end
  end

  assign bus.row       = row_q;
  assign bus.value     = value_q;
  assign bus.digits    = digits_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = key_code_q;
  assign bus.entry     = entry_q;
  assign bus.entry_stb = entry_stb_q;

endmodule
